// File: rtl/clkdiv_sched.sv
// Round-robin owner scheduler for the shared clkdiv instance.
// It mirrors the clkdiv modulo counter so that div only changes at an output-period boundary.
module clkdiv_sched #(
    parameter int unsigned     NREQ    = 4,
    parameter int unsigned     DIV_W   = 12,
    parameter logic [DIV_W-1:0] DEF_DIV = 12'd4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DIV_W-1:0]   div_req,
    output logic [NREQ-1:0]         gnt,
    output logic [DIV_W-1:0]        div,
    output logic                    phase0,
    output logic                    busy,
    output logic                    bad_div
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT,
        S_OWN,
        S_REL
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   nd;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   cand;

    logic               arb_hit_c;
    logic [IDX_W-1:0]   arb_idx_c;
    logic [DIV_W-1:0]   arb_div_c;
    logic [DIV_W-1:0]   nd_c;
    logic               zero_c;
    logic               bnd_c;
    logic [IDX_W-1:0]   nxt_ptr_c;

    // Round-robin scan starting at rr_ptr; the first active request wins.
    always_comb begin : arb
        int j;
        logic [IDX_W-1:0] idx;
        arb_hit_c = 1'b0;
        arb_idx_c = '0;
        j         = 0;
        idx       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = int'(rr_ptr) + k;
            if (j >= int'(NREQ)) begin
                j = j - int'(NREQ);
            end
            idx = IDX_W'(j);
            if (!arb_hit_c && req[idx]) begin
                arb_hit_c = 1'b1;
                arb_idx_c = idx;
            end
        end
    end

    always_comb begin
        arb_div_c = div_req[int'(arb_idx_c) * int'(DIV_W) +: DIV_W];
        zero_c    = (arb_div_c == '0);
        nd_c      = zero_c ? DIV_W'(1) : arb_div_c;
        bnd_c     = (cnt == div - DIV_W'(1));
        nxt_ptr_c = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + IDX_W'(1);
    end

    // Mirror counter, arbitration FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            div     <= DEF_DIV;
            cnt     <= '0;
            nd      <= DEF_DIV;
            rr_ptr  <= '0;
            cand    <= '0;
            phase0  <= 1'b0;
            busy    <= 1'b0;
            bad_div <= 1'b0;
        end else begin
            bad_div <= 1'b0;
            cnt     <= bnd_c ? '0 : cnt + DIV_W'(1);
            phase0  <= bnd_c;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state <= S_ARB;
                        busy  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (arb_hit_c) begin
                        cand    <= arb_idx_c;
                        nd      <= nd_c;
                        bad_div <= zero_c;
                        state   <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // The new ratio and the grant land together on the wrap edge.
                    if (bnd_c) begin
                        if (req[cand]) begin
                            div    <= nd;
                            gnt    <= NREQ'(1) << cand;
                            rr_ptr <= nxt_ptr_c;
                            state  <= S_OWN;
                        end else if (|req) begin
                            state <= S_ARB;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_OWN: begin
                    if (!req[cand]) begin
                        gnt   <= '0;
                        state <= S_REL;
                    end
                end
                S_REL: begin
                    if (arb_hit_c) begin
                        cand    <= arb_idx_c;
                        nd      <= nd_c;
                        bad_div <= zero_c;
                        state   <= S_WAIT;
                    end else begin
                        nd <= DEF_DIV;
                        if (bnd_c) begin
                            div   <= DEF_DIV;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed bench for clkdiv_sched: reset, grant latency, round-robin order, zero ratio and reset abort.
// Background monitors check one-hot grants and that div only moves on a phase0 cycle.
module tb_clkdiv_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DIV_W = 12;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DIV_W-1:0] div_req;
    logic [NREQ-1:0]       gnt;
    logic [DIV_W-1:0]      div;
    logic                  phase0;
    logic                  busy;
    logic                  bad_div;

    int n_cmp = 0;
    int n_bad = 0;

    clkdiv_sched #(.NREQ(NREQ), .DIV_W(DIV_W), .DEF_DIV(12'd4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .div_req (div_req),
        .gnt     (gnt),
        .div     (div),
        .phase0  (phase0),
        .busy    (busy),
        .bad_div (bad_div)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_div(input int i, input logic [DIV_W-1:0] v);
        div_req[i*int'(DIV_W) +: DIV_W] = v;
    endtask

    // Steps until phase0 is seen (at least one step), bounded by max.
    task automatic wait_phase0(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (phase0 !== 1'b1 && n < max);
    endtask

    task automatic wait_gnt(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (gnt === '0 && n < max);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy !== 1'b0 && n < max);
    endtask

    // Monitors: div may only change together with phase0, grants stay one-hot.
    logic             rst_edge = 1'b1;
    logic [DIV_W-1:0] prev_div;
    logic [NREQ-1:0]  prev_gnt = '0;

    always @(posedge clk) rst_edge <= rst;

    always @(negedge clk) begin
        if (!rst_edge && div !== prev_div) begin
            n_cmp++;
            assert (phase0 === 1'b1) else begin
                n_bad++;
                $error("FAIL div_off_boundary: observed phase0=%0b div %0d->%0d expected phase0=1",
                       phase0, prev_div, div);
            end
        end
        if (gnt !== prev_gnt) begin
            n_cmp++;
            assert ($onehot0(gnt)) else begin
                n_bad++;
                $error("FAIL gnt_onehot: observed=%b expected at most one bit", gnt);
            end
        end
        prev_div = div;
        prev_gnt = gnt;
    end

    initial begin
        int n;
        int order[4];
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        rst     = 1'b1;
        req     = '0;
        div_req = '0;

        // T1 reset and default period
        step();
        step();
        chk("t1_gnt", 32'(gnt), 0);
        chk("t1_div", 32'(div), 4);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_phase0", 32'(phase0), 0);
        chk("t1_bad_div", 32'(bad_div), 0);
        rst = 1'b0;
        wait_phase0(20, n);
        chk("t1_first_period", 32'(n), 4);
        wait_phase0(20, n);
        chk("t1_period", 32'(n), 4);

        // T2 single requester from IDLE, cnt=0 at this point
        req[0] = 1'b1;
        set_div(0, 12'd6);
        wait_gnt(20, n);
        chk("t2_latency", 32'(n), 4);
        chk("t2_gnt", 32'(gnt), 32'b0001);
        chk("t2_div", 32'(div), 6);
        chk("t2_phase0_at_gnt", 32'(phase0), 1);
        chk("t2_busy", 32'(busy), 1);
        wait_phase0(20, n);
        chk("t2_period", 32'(n), 6);

        // T3 second requester waits, then takes over at the next 6-boundary
        req[2] = 1'b1;
        set_div(2, 12'd10);
        step();
        step();
        step();
        chk("t3_no_preempt", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        step();
        chk("t3_release_gnt", 32'(gnt), 0);
        chk("t3_release_busy", 32'(busy), 1);
        wait_gnt(20, n);
        chk("t3_handover_steps", 32'(n), 2);
        chk("t3_gnt2", 32'(gnt), 32'b0100);
        chk("t3_div10", 32'(div), 10);
        req[2] = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (div !== 12'd4 && n < 40);
        chk("t3_restore_steps", 32'(n), 10);
        chk("t3_restore_busy", 32'(busy), 0);
        chk("t3_restore_gnt", 32'(gnt), 0);

        // T4 fairness: two requesters keep releasing and re-requesting
        set_div(0, 12'd6);
        set_div(1, 12'd3);
        req[0] = 1'b1;
        req[1] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_gnt(30, n);
            order[r] = (gnt === 4'b0001) ? 0 : (gnt === 4'b0010) ? 1 : -1;
            chk($sformatf("t4_round%0d", r), 32'(order[r]), 32'(exp_order[r]));
            if (order[r] >= 0) begin
                req[order[r]] = 1'b0;
                step();
                req[order[r]] = 1'b1;
            end
        end
        req = '0;
        wait_idle(40);
        chk("t4_idle_busy", 32'(busy), 0);
        chk("t4_idle_div", 32'(div), 4);

        // T5 zero ratio is forced to 1
        set_div(1, 12'd0);
        req[1] = 1'b1;
        step();
        chk("t5_no_early_bad_div", 32'(bad_div), 0);
        step();
        chk("t5_bad_div_pulse", 32'(bad_div), 1);
        step();
        chk("t5_bad_div_cleared", 32'(bad_div), 0);
        wait_gnt(20, n);
        chk("t5_gnt1", 32'(gnt), 32'b0010);
        chk("t5_div1", 32'(div), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t5_phase0_cont%0d", i), 32'(phase0), 1);
            chk($sformatf("t5_bad_div_quiet%0d", i), 32'(bad_div), 0);
        end

        // T6 reset while owning div=10 at cnt=3
        req[1] = 1'b0;
        wait_idle(20);
        chk("t6_idle_div", 32'(div), 4);
        set_div(0, 12'd10);
        req[0] = 1'b1;
        wait_gnt(20, n);
        chk("t6_gnt0", 32'(gnt), 32'b0001);
        chk("t6_div10", 32'(div), 10);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_div", 32'(div), 4);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_phase0", 32'(phase0), 0);
        rst    = 1'b0;
        req[0] = 1'b0;
        wait_phase0(20, n);
        chk("t6_cnt_restart", 32'(n), 4);
        chk("t6_stays_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
